hazard_scoreboard: RTL

- Parametrised hazard unit for the 5-stage MIPS pipeline; replaces the fixed combinational EXE/MEM compare in the top level.
- Keeps its own shift-register record of in-flight register writes, one slot per stage after ID (slot 0 = EXE, last slot = WB).
- From that record it produces the ID stall and, when forwarding is enabled, per-operand bypass selects.
- Supports a global pipeline hold, branch flush, a configurable load-use latency, and a saturating stall-cycle counter for the LCD debug display.

---
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: tracks in-flight register writes per stage
// and produces the ID stall plus optional per-operand bypass selects.
module hazard_scoreboard #(
  parameter int AW          = 5,
  parameter int DEPTH       = 3,
  parameter int FWD         = 1,
  parameter int LOAD_READY  = 2,
  parameter int FLUSH_DEPTH = 1,
  parameter int SW_CNT      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hold,
  input  logic                           flush,
  input  logic                           id_valid,
  input  logic [AW-1:0]                  id_rs,
  input  logic [AW-1:0]                  id_rt,
  input  logic                           id_rs_used,
  input  logic                           id_rt_used,
  input  logic                           id_wen,
  input  logic [AW-1:0]                  id_waddr,
  input  logic                           id_is_load,
  output logic                           stall,
  output logic [$clog2(DEPTH+1)-1:0]     fwd_a_sel,
  output logic [$clog2(DEPTH+1)-1:0]     fwd_b_sel,
  output logic [SW_CNT-1:0]              stall_cnt,
  output logic [DEPTH-1:0]               slot_valid
);

  localparam int SW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] ld;
  logic [AW-1:0]    a [DEPTH];

  logic [DEPTH-1:0] m_a, m_b;
  logic             hit_a, hit_b, early_a, early_b, pld_a, pld_b, stall_raw;
  logic [SW-1:0]    p_a, p_b;

  always_comb begin
    m_a = '0;
    m_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      m_a[k] = id_valid & id_rs_used & (id_rs != '0) & v[k] & (a[k] == id_rs);
      m_b[k] = id_valid & id_rt_used & (id_rt != '0) & v[k] & (a[k] == id_rt);
    end
  end

  // Scan oldest to youngest so the youngest (lowest k) producer is left standing.
  always_comb begin
    hit_a = 1'b0; p_a = '0; pld_a = 1'b0; early_a = 1'b0;
    hit_b = 1'b0; p_b = '0; pld_b = 1'b0; early_b = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (m_a[k]) begin
        hit_a = 1'b1; p_a = SW'(k); pld_a = ld[k]; early_a = (k < LOAD_READY);
      end
      if (m_b[k]) begin
        hit_b = 1'b1; p_b = SW'(k); pld_b = ld[k]; early_b = (k < LOAD_READY);
      end
    end
  end

  always_comb begin
    stall_raw = 1'b0;
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    if (FWD == 0) begin
      // WB slot is skipped: the register file writes before it reads.
      for (int k = 0; k < DEPTH-1; k++)
        stall_raw = stall_raw | m_a[k] | m_b[k];
    end else begin
      stall_raw = (hit_a & pld_a & early_a) | (hit_b & pld_b & early_b);
      if (!stall_raw) begin
        if (hit_a) fwd_a_sel = p_a + SW'(1);
        if (hit_b) fwd_b_sel = p_b + SW'(1);
      end
    end
    stall = stall_raw & ~flush;
  end

  assign slot_valid = v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v         <= '0;
      ld        <= '0;
      stall_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) a[k] <= '0;
    end else if (!hold) begin
      v[0]  <= id_valid & ~stall & ~flush & id_wen & (id_waddr != '0);
      a[0]  <= id_waddr;
      ld[0] <= id_is_load;
      for (int k = 1; k < DEPTH; k++) begin
        a[k]  <= a[k-1];
        ld[k] <= ld[k-1];
        v[k]  <= (flush && (k < FLUSH_DEPTH)) ? 1'b0 : v[k-1];
      end
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
